// File: rtl/dma_lstm_port.sv
// LSTM-side endpoint of the main-memory DMA path: owns the local word buffer,
// captures memory read data on loads and sources write data on stores.
module dma_lstm_port #(
   parameter int MAIN_MEM_ADD_LEN = 11,
   parameter int DATA_W           = 16,
   parameter int BUF_DEPTH        = 64,
   parameter int BUF_ADD_LEN      = 6
) (
   input  logic                        fpga_clk,
   input  logic                        reset_n,
   input  logic                        direct,
   input  logic                        start,
   input  logic [MAIN_MEM_ADD_LEN-1:0] main_mem_count,
   input  logic                        main_mem_oe,
   input  logic [DATA_W-1:0]           main_mem_rd_data,
   input  logic                        main_mem_we_delayed,
   output logic [DATA_W-1:0]           main_mem_wr_data,
   input  logic [BUF_ADD_LEN-1:0]      lstm_rd_addr,
   output logic [DATA_W-1:0]           lstm_rd_data,
   input  logic                        lstm_wr_en,
   input  logic [BUF_ADD_LEN-1:0]      lstm_wr_addr,
   input  logic [DATA_W-1:0]           lstm_wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        count_err
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

   localparam logic [MAIN_MEM_ADD_LEN:0]   DEPTH_EXT = (MAIN_MEM_ADD_LEN+1)'(BUF_DEPTH);
   localparam logic [MAIN_MEM_ADD_LEN-1:0] CNT_ONE   = MAIN_MEM_ADD_LEN'(1);
   localparam logic [BUF_ADD_LEN:0]        PTR_ONE   = (BUF_ADD_LEN+1)'(1);

   state_t                      state;
   logic [BUF_ADD_LEN:0]        ptr;
   logic [MAIN_MEM_ADD_LEN-1:0] cnt_q;
   logic                        oe_d;
   logic [DATA_W-1:0]           buf_mem [BUF_DEPTH];

   logic [MAIN_MEM_ADD_LEN-1:0] ptr_ext;
   logic [BUF_ADD_LEN-1:0]      ptr_idx;
   logic                        last_word;
   logic                        capture;
   logic                        store_step;
   logic                        count_zero;
   logic                        count_over;
   logic                        side_wr_ok;

   assign ptr_ext    = MAIN_MEM_ADD_LEN'(ptr);
   assign ptr_idx    = ptr[BUF_ADD_LEN-1:0];
   assign last_word  = (ptr_ext == (cnt_q - CNT_ONE));
   assign capture    = (state == LOAD) && oe_d;
   assign store_step = (state == STORE) && main_mem_we_delayed;
   assign count_zero = (main_mem_count == '0);
   assign count_over = ({1'b0, main_mem_count} > DEPTH_EXT);
   assign side_wr_ok = (state == IDLE) || (state == DONE);

   // Read data returns one cycle after the strobe, so the capture strobe is delayed to match.
   always_ff @(posedge fpga_clk or negedge reset_n) begin
      if (!reset_n) oe_d <= 1'b0;
      else          oe_d <= main_mem_oe;
   end

   always_ff @(posedge fpga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         count_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (count_zero) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (count_over) begin
                     count_err <= 1'b1;
                     state     <= DONE;
                     done      <= 1'b1;
                  end else begin
                     cnt_q     <= main_mem_count;
                     ptr       <= '0;
                     count_err <= 1'b0;
                     busy      <= 1'b1;
                     state     <= direct ? STORE : LOAD;
                  end
               end
            end
            LOAD: begin
               if (capture) begin
                  ptr <= ptr + PTR_ONE;
                  if (last_word) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            STORE: begin
               if (store_step) begin
                  ptr <= ptr + PTR_ONE;
                  if (last_word) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Side-port writes are only accepted while no transfer owns the buffer.
   always_ff @(posedge fpga_clk) begin
      if (capture)
         buf_mem[ptr_idx] <= main_mem_rd_data;
      else if (lstm_wr_en && side_wr_ok)
         buf_mem[lstm_wr_addr] <= lstm_wr_data;
   end

   assign lstm_rd_data     = buf_mem[lstm_rd_addr];
   assign main_mem_wr_data = store_step ? buf_mem[ptr_idx] : '0;

endmodule

// File: tb/tb_dma_lstm_port.sv
// Bench for dma_lstm_port: directed transfer table, corner-case sequences and
// randomized transfers checked against a transfer-progress model.
module tb_dma_lstm_port;
   localparam int MAIN_MEM_ADD_LEN = 11;
   localparam int DATA_W           = 16;
   localparam int BUF_DEPTH        = 64;
   localparam int BUF_ADD_LEN      = 6;

   logic                        fpga_clk = 1'b0;
   logic                        reset_n;
   logic                        direct;
   logic                        start;
   logic [MAIN_MEM_ADD_LEN-1:0] main_mem_count;
   logic                        main_mem_oe;
   logic [DATA_W-1:0]           main_mem_rd_data;
   logic                        main_mem_we_delayed;
   logic [DATA_W-1:0]           main_mem_wr_data;
   logic [BUF_ADD_LEN-1:0]      lstm_rd_addr;
   logic [DATA_W-1:0]           lstm_rd_data;
   logic                        lstm_wr_en;
   logic [BUF_ADD_LEN-1:0]      lstm_wr_addr;
   logic [DATA_W-1:0]           lstm_wr_data;
   logic                        busy;
   logic                        done;
   logic                        count_err;

   dma_lstm_port #(
      .MAIN_MEM_ADD_LEN(MAIN_MEM_ADD_LEN), .DATA_W(DATA_W),
      .BUF_DEPTH(BUF_DEPTH), .BUF_ADD_LEN(BUF_ADD_LEN)
   ) dut (
      .fpga_clk(fpga_clk), .reset_n(reset_n), .direct(direct), .start(start),
      .main_mem_count(main_mem_count), .main_mem_oe(main_mem_oe),
      .main_mem_rd_data(main_mem_rd_data), .main_mem_we_delayed(main_mem_we_delayed),
      .main_mem_wr_data(main_mem_wr_data), .lstm_rd_addr(lstm_rd_addr),
      .lstm_rd_data(lstm_rd_data), .lstm_wr_en(lstm_wr_en), .lstm_wr_addr(lstm_wr_addr),
      .lstm_wr_data(lstm_wr_data), .busy(busy), .done(done), .count_err(count_err)
   );

   always #5 fpga_clk = ~fpga_clk;

   // Reference model: buffer contents plus progress of the current transfer.
   logic [DATA_W-1:0] mdl_buf [BUF_DEPTH];
   bit                mdl_vld [BUF_DEPTH];
   bit                m_active, m_dir, m_done_now, m_oe_prev, m_err;
   int                m_n, m_prog;

   int n_vec, n_err;
   int done_seen;
   bit cyc_done;

   typedef struct {
      bit          dir;
      int          count;
      logic [15:0] base;
      logic [15:0] step;
      bit          pre_a0;
      int          exp_done;
      bit          exp_err;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      start               = 1'b0;
      main_mem_oe         = 1'b0;
      main_mem_we_delayed = 1'b0;
      lstm_wr_en          = 1'b0;
   endtask

   task automatic model_reset();
      m_active   = 1'b0;
      m_done_now = 1'b0;
      m_err      = 1'b0;
      m_oe_prev  = 1'b0;
      m_prog     = 0;
      m_n        = 0;
      for (int i = 0; i < BUF_DEPTH; i++) mdl_vld[i] = 1'b0;
   endtask

   // Called at posedge+1 with this cycle's inputs already driven.
   task automatic run_cycle();
      logic [DATA_W-1:0] exp_wr;
      bit                new_done;
      int                nd;
      #2;
      exp_wr = (m_active && m_dir && main_mem_we_delayed) ? mdl_buf[m_prog] : '0;
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done_now));
      chk("count_err", 32'(count_err), 32'(m_err));
      chk("wr_data", 32'(main_mem_wr_data), 32'(exp_wr));
      if (mdl_vld[lstm_rd_addr])
         chk("rd_data", 32'(lstm_rd_data), 32'(mdl_buf[lstm_rd_addr]));
      cyc_done = (done === 1'b1);
      if (cyc_done) done_seen++;
      new_done = 1'b0;
      if (m_active) begin
         if (!m_dir && m_oe_prev) begin
            mdl_buf[m_prog] = main_mem_rd_data;
            mdl_vld[m_prog] = 1'b1;
            m_prog++;
         end else if (m_dir && main_mem_we_delayed) begin
            m_prog++;
         end
         if (m_prog == m_n) begin
            m_active = 1'b0;
            new_done = 1'b1;
         end
      end else begin
         if (lstm_wr_en) begin
            mdl_buf[lstm_wr_addr] = lstm_wr_data;
            mdl_vld[lstm_wr_addr] = 1'b1;
         end
         if (start && !m_done_now) begin
            nd = int'(main_mem_count);
            if (nd == 0) new_done = 1'b1;
            else if (nd > BUF_DEPTH) begin
               m_err    = 1'b1;
               new_done = 1'b1;
            end else begin
               m_err    = 1'b0;
               m_active = 1'b1;
               m_dir    = direct;
               m_n      = nd;
               m_prog   = 0;
            end
         end
      end
      m_oe_prev  = main_mem_oe;
      m_done_now = new_done;
      @(posedge fpga_clk);
      #1;
   endtask

   task automatic rand_side();
      idle_inputs();
      main_mem_oe         = 1'($urandom);
      main_mem_we_delayed = 1'($urandom);
      lstm_wr_en          = 1'($urandom);
      lstm_wr_addr        = 6'($urandom);
      lstm_wr_data        = 16'($urandom);
      lstm_rd_addr        = 6'($urandom);
      main_mem_rd_data    = 16'($urandom);
   endtask

   initial begin
      int n_str, first_done, n, guard, gap;
      n_vec = 0;
      n_err = 0;
      done_seen = 0;
      model_reset();
      tbl[0] = '{1'b0, 4,    16'h0011, 16'h0011, 1'b0, 5,  1'b0};
      tbl[1] = '{1'b1, 6,    16'h0000, 16'h0000, 1'b1, 7,  1'b0};
      tbl[2] = '{1'b0, 0,    16'h0000, 16'h0000, 1'b0, 1,  1'b0};
      tbl[3] = '{1'b0, 65,   16'hBEEF, 16'h0001, 1'b0, 1,  1'b1};
      tbl[4] = '{1'b0, 64,   16'h1000, 16'h0003, 1'b0, 65, 1'b0};
      tbl[5] = '{1'b1, 65,   16'h0000, 16'h0000, 1'b0, 1,  1'b1};
      tbl[6] = '{1'b1, 1,    16'h0000, 16'h0000, 1'b0, 2,  1'b0};

      reset_n = 1'b0;
      direct = 1'b0;
      main_mem_count = '0;
      main_mem_rd_data = '0;
      lstm_rd_addr = '0;
      lstm_wr_addr = '0;
      lstm_wr_data = '0;
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         @(posedge fpga_clk);
         #3;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_err", 32'(count_err), 32'd0);
         chk("rst_wr_data", 32'(main_mem_wr_data), 32'd0);
      end
      @(posedge fpga_clk);
      #1;
      reset_n = 1'b1;
      run_cycle();

      // Directed transfer table
      for (int v = 0; v < 7; v++) begin
         if (tbl[v].pre_a0) begin
            for (int i = 0; i < 6; i++) begin
               idle_inputs();
               lstm_wr_en   = 1'b1;
               lstm_wr_addr = 6'(i);
               lstm_wr_data = 16'h00A0 + 16'(i);
               run_cycle();
            end
         end
         n_str = (tbl[v].count > BUF_DEPTH) ? 3 : tbl[v].count;
         first_done = -1;
         done_seen = 0;
         for (int t = 0; t <= n_str + 3; t++) begin
            idle_inputs();
            if (t == 0) begin
               start          = 1'b1;
               direct         = tbl[v].dir;
               main_mem_count = 11'(tbl[v].count);
            end
            if (!tbl[v].dir && t < n_str) main_mem_oe = 1'b1;
            if (tbl[v].dir && t >= 1 && t <= n_str) main_mem_we_delayed = 1'b1;
            main_mem_rd_data = tbl[v].base + 16'(t - 1) * tbl[v].step;
            lstm_rd_addr = 6'(t);
            run_cycle();
            if (cyc_done && first_done < 0) first_done = t;
         end
         chk($sformatf("v%0d_done_cycle", v), 32'(first_done), 32'(tbl[v].exp_done));
         chk($sformatf("v%0d_done_pulses", v), 32'(done_seen), 32'd1);
         chk($sformatf("v%0d_count_err", v), 32'(count_err), 32'(tbl[v].exp_err));
         if (!tbl[v].dir && !tbl[v].exp_err) begin
            for (int i = 0; i < tbl[v].count; i++) begin
               lstm_rd_addr = 6'(i);
               #1;
               chk($sformatf("v%0d_readback%0d", v, i), 32'(lstm_rd_data),
                   32'(tbl[v].base + 16'(i) * tbl[v].step));
            end
            @(posedge fpga_clk);
            #1;
         end
      end

      // Load N=8 with a second start and a colliding side write in cycle 3
      done_seen = 0;
      for (int t = 0; t <= 11; t++) begin
         idle_inputs();
         if (t == 0) begin
            start = 1'b1; direct = 1'b0; main_mem_count = 11'd8;
         end
         if (t == 3) begin
            start = 1'b1; direct = 1'b1; main_mem_count = 11'd2;
            lstm_wr_en = 1'b1; lstm_wr_addr = 6'd2; lstm_wr_data = 16'hFFFF;
         end
         if (t < 8) main_mem_oe = 1'b1;
         main_mem_rd_data = 16'h5000 + 16'(t - 1);
         lstm_rd_addr = 6'd2;
         run_cycle();
      end
      chk("ovl_done_pulses", 32'(done_seen), 32'd1);
      lstm_rd_addr = 6'd2;
      #1;
      chk("ovl_buf2", 32'(lstm_rd_data), 32'h5002);
      @(posedge fpga_clk);
      #1;

      // Rejected start leaves count_err set; reset mid-load must clear it
      idle_inputs();
      start = 1'b1; direct = 1'b0; main_mem_count = 11'd100;
      run_cycle();
      idle_inputs();
      run_cycle();
      for (int t = 0; t <= 2; t++) begin
         idle_inputs();
         if (t == 0) begin
            start = 1'b1; direct = 1'b0; main_mem_count = 11'd8;
         end
         main_mem_oe = 1'b1;
         main_mem_rd_data = 16'h6000 + 16'(t - 1);
         run_cycle();
      end
      idle_inputs();
      main_mem_oe = 1'b1;
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #2;
         chk("mid_rst_busy", 32'(busy), 32'd0);
         chk("mid_rst_done", 32'(done), 32'd0);
         chk("mid_rst_err", 32'(count_err), 32'd0);
         chk("mid_rst_wr_data", 32'(main_mem_wr_data), 32'd0);
         @(posedge fpga_clk);
         #1;
      end
      model_reset();
      idle_inputs();
      reset_n = 1'b1;
      run_cycle();
      first_done = -1;
      done_seen = 0;
      for (int t = 0; t <= 5; t++) begin
         idle_inputs();
         if (t == 0) begin
            start = 1'b1; direct = 1'b0; main_mem_count = 11'd2;
         end
         if (t < 2) main_mem_oe = 1'b1;
         main_mem_rd_data = 16'h7000 + 16'(t - 1);
         lstm_rd_addr = 6'(t);
         run_cycle();
         if (cyc_done && first_done < 0) first_done = t;
      end
      chk("post_rst_done_cycle", 32'(first_done), 32'd3);
      chk("post_rst_done_pulses", 32'(done_seen), 32'd1);

      // Strobes while IDLE must not touch the buffer or the write bus
      idle_inputs();
      main_mem_oe = 1'b1; main_mem_we_delayed = 1'b1;
      main_mem_rd_data = 16'hDEAD; lstm_rd_addr = 6'd0;
      run_cycle();
      idle_inputs();
      main_mem_we_delayed = 1'b1; main_mem_rd_data = 16'hDEAD; lstm_rd_addr = 6'd1;
      run_cycle();
      idle_inputs();
      run_cycle();
      lstm_rd_addr = 6'd0;
      #1;
      chk("idle_strobe_buf0", 32'(lstm_rd_data), 32'h7000);
      lstm_rd_addr = 6'd1;
      #1;
      chk("idle_strobe_buf1", 32'(lstm_rd_data), 32'h7001);
      @(posedge fpga_clk);
      #1;

      // Randomized transfers
      for (int i = 0; i < BUF_DEPTH; i++) begin
         idle_inputs();
         lstm_wr_en = 1'b1;
         lstm_wr_addr = 6'(i);
         lstm_wr_data = 16'($urandom);
         lstm_rd_addr = 6'($urandom);
         run_cycle();
      end
      for (int k = 0; k < 25; k++) begin
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            rand_side();
            run_cycle();
         end
         case ($urandom_range(0, 9))
            0:       n = 0;
            1:       n = $urandom_range(65, 70);
            2:       n = 2047;
            3:       n = 64;
            default: n = $urandom_range(1, 64);
         endcase
         rand_side();
         start = 1'b1;
         direct = 1'($urandom);
         main_mem_count = 11'(n);
         run_cycle();
         guard = 0;
         while ((m_active || m_done_now) && guard < 1000) begin
            rand_side();
            main_mem_oe = ($urandom_range(0, 3) != 0);
            main_mem_we_delayed = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
               start = 1'b1;
               direct = 1'($urandom);
               main_mem_count = 11'($urandom_range(0, 80));
            end
            run_cycle();
            guard++;
         end
         if (guard >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL rand_xfer%0d_bound: transfer still active after %0d cycles, required completion", k, guard);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
